// File: rtl/nibble_serial_adder16_pkg.sv
// Shared types and defaults for the nibble-serial adder/subtractor.
// State encodings: IDLE=0, RUN=1, DONE=2.
package nibble_serial_adder16_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_NIBBLES = 4;

    // Nibble index width; at least one bit so NIBBLES=1 still has a legal counter.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_adder16_if.sv
// Operand and result handshakes of the nibble-serial adder/subtractor.
// slave is the adder's view; master is the source/consumer view.
interface nibble_serial_adder16_if
    import nibble_serial_adder16_pkg::*;
#(
    parameter int unsigned NIBBLES = DEFAULT_NIBBLES
);
    localparam int unsigned W = 4 * NIBBLES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         SUB;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] S;
    logic         Cout;
    logic         OVF;

    modport slave (
        input  in_valid, A, B, Cin, SUB, out_ready,
        output in_ready, out_valid, S, Cout, OVF
    );

    modport master (
        output in_valid, A, B, Cin, SUB, out_ready,
        input  in_ready, out_valid, S, Cout, OVF
    );

endinterface

// File: rtl/nibble_serial_adder16_cla4_slice.sv
// Combinational 4-bit propagate/generate lookahead adder slice.
// C3 (carry into bit 3) is exported for signed-overflow detection.
module cla4_slice (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout,
    output logic       C3
);

    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    always_comb begin
        p    = A ^ B;
        g    = A & B;
        c[0] = Cin;
        c[1] = g[0] | (p[0] & Cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & Cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | ((&p) & Cin);
    end

    assign S    = p ^ c[3:0];
    assign Cout = c[4];
    assign C3   = c[3];

endmodule

// File: rtl/nibble_serial_adder16.sv
// Multi-cycle W-bit adder/subtractor reusing one 4-bit lookahead slice,
// one nibble per clock, LSB first, with valid/ready on both sides.
module nibble_serial_adder16
    import nibble_serial_adder16_pkg::*;
#(
    parameter int unsigned NIBBLES = DEFAULT_NIBBLES
) (
    input  logic                    clk,
    input  logic                    rst,
    nibble_serial_adder16_if.slave  bus
);

    localparam int unsigned W    = 4 * NIBBLES;
    localparam int unsigned IDXW = idx_width(NIBBLES);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

    state_t          state;
    state_t          state_nxt;
    logic [W-1:0]    opa;
    logic [W-1:0]    opb;
    logic [W-1:0]    s_q;
    logic            carry;
    logic            cout_q;
    logic            ovf_q;
    logic [IDXW-1:0] idx;

    logic [3:0]      a_nib;
    logic [3:0]      b_nib;
    logic [3:0]      sl_s;
    logic            sl_cout;
    logic            sl_c3;
    logic            last;

    assign a_nib = opa[idx*4 +: 4];
    assign b_nib = opb[idx*4 +: 4];
    assign last  = (idx == LAST_IDX);

    cla4_slice u_slice (
        .A    (a_nib),
        .B    (b_nib),
        .Cin  (carry),
        .S    (sl_s),
        .Cout (sl_cout),
        .C3   (sl_c3)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = RUN;
            RUN:     if (last)         state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Subtraction is folded into the capture: A + ~B + 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            opa    <= '0;
            opb    <= '0;
            s_q    <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            idx    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        opa   <= bus.A;
                        opb   <= bus.SUB ? ~bus.B : bus.B;
                        carry <= bus.SUB ? 1'b1 : bus.Cin;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    s_q[idx*4 +: 4] <= sl_s;
                    carry           <= sl_cout;
                    if (last) begin
                        cout_q <= sl_cout;
                        ovf_q  <= sl_c3 ^ sl_cout;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = (state == DONE);
    assign bus.S         = s_q;
    assign bus.Cout      = cout_q;
    assign bus.OVF       = ovf_q;

endmodule
